// File: rtl/data_bus_master_if.sv
// Data-memory bus between the load/store initiator and the memory side.
// The master drives strobes, address and store data; the slave returns read data.
interface data_bus_master_if #(
  parameter int ADDR_W = 32
);
  logic              wReadEnable;
  logic              wWriteEnable;
  logic [3:0]        wByteEnable;
  logic [ADDR_W-1:0] wAddress;
  logic [31:0]       wWriteData;
  logic [31:0]       wReadData;

  modport master (
    output wReadEnable,
    output wWriteEnable,
    output wByteEnable,
    output wAddress,
    output wWriteData,
    input  wReadData
  );

  modport slave (
    input  wReadEnable,
    input  wWriteEnable,
    input  wByteEnable,
    input  wAddress,
    input  wWriteData,
    output wReadData
  );
endinterface

// File: rtl/data_bus_master.sv
// Single-outstanding load/store initiator for the CPU data bus with lane steering and load extension.
// Optional macro ALIGN_EXC_EN: misaligned requests complete immediately with oExcAddr instead of being force-aligned.
module data_bus_master #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iReq,
  input  logic              iWrite,
  input  logic [1:0]        iSize,
  input  logic              iUnsigned,
  input  logic [ADDR_W-1:0] iAddr,
  input  logic [31:0]       iStoreData,
  output logic              oBusy,
  output logic              oDone,
  output logic [31:0]       oLoadData,
  output logic              oExcAddr,
  data_bus_master_if.master bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  // A wait count of 0 is treated as a single-cycle access.
  localparam int WaitEff = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
  localparam int CntW    = (WaitEff > 1) ? $clog2(WaitEff) : 1;
  localparam logic [CntW-1:0] LastCount = CntW'(WaitEff - 1);

  logic [1:0]        state;
  logic [CntW-1:0]   count;
  logic              writeReg;
  logic [1:0]        sizeReg;
  logic              unsignedReg;
  logic [3:0]        reqBe;
  logic [31:0]       reqData;
  logic [ADDR_W-1:0] reqAddr;
  logic [31:0]       lane;
  logic [31:0]       loadExt;

`ifdef ALIGN_EXC_EN
  logic misaligned;
  logic excFlag;
`endif

  always_comb begin
    reqAddr = iAddr;
    reqBe   = 4'b1111;
    reqData = iStoreData;
`ifdef ALIGN_EXC_EN
    misaligned = 1'b0;
`endif
    case (iSize)
      2'b00: begin
        reqBe   = 4'b0001 << iAddr[1:0];
        reqData = {4{iStoreData[7:0]}};
      end
      2'b01: begin
`ifdef ALIGN_EXC_EN
        misaligned = iAddr[0];
`else
        reqAddr[0] = 1'b0;
`endif
        reqBe   = 4'b0011 << {iAddr[1], 1'b0};
        reqData = {2{iStoreData[15:0]}};
      end
      default: begin
`ifdef ALIGN_EXC_EN
        misaligned = |iAddr[1:0];
`else
        reqAddr[1:0] = 2'b00;
`endif
        reqBe   = 4'b1111;
        reqData = iStoreData;
      end
    endcase
  end

  // The captured address is already aligned, so a byte shift also serves halves and words.
  always_comb begin
    lane    = bus.wReadData >> {bus.wAddress[1:0], 3'b000};
    loadExt = lane;
    case (sizeReg)
      2'b00:   loadExt = unsignedReg ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      2'b01:   loadExt = unsignedReg ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: loadExt = lane;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state            <= IDLE;
      count            <= '0;
      writeReg         <= 1'b0;
      sizeReg          <= 2'b00;
      unsignedReg      <= 1'b0;
      oLoadData        <= '0;
      bus.wReadEnable  <= 1'b0;
      bus.wWriteEnable <= 1'b0;
      bus.wByteEnable  <= 4'b0000;
      bus.wAddress     <= '0;
      bus.wWriteData   <= '0;
`ifdef ALIGN_EXC_EN
      excFlag          <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (iReq) begin
            writeReg       <= iWrite;
            sizeReg        <= iSize;
            unsignedReg    <= iUnsigned;
            bus.wAddress   <= reqAddr;
            bus.wWriteData <= reqData;
            count          <= '0;
`ifdef ALIGN_EXC_EN
            excFlag        <= misaligned;
            if (misaligned) begin
              state <= DONE;
            end else begin
              state            <= ACCESS;
              bus.wByteEnable  <= reqBe;
              bus.wReadEnable  <= ~iWrite;
              bus.wWriteEnable <= iWrite;
            end
`else
            state            <= ACCESS;
            bus.wByteEnable  <= reqBe;
            bus.wReadEnable  <= ~iWrite;
            bus.wWriteEnable <= iWrite;
`endif
          end
        end
        ACCESS: begin
          if (count == LastCount) begin
            state            <= DONE;
            bus.wReadEnable  <= 1'b0;
            bus.wWriteEnable <= 1'b0;
            bus.wByteEnable  <= 4'b0000;
            if (!writeReg) begin
              oLoadData <= loadExt;
            end
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          count <= '0;
`ifdef ALIGN_EXC_EN
          excFlag <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign oBusy = (state != IDLE);
  assign oDone = (state == DONE);

`ifdef ALIGN_EXC_EN
  assign oExcAddr = (state == DONE) && excFlag;
`else
  assign oExcAddr = 1'b0;
`endif

endmodule
